// File: rtl/spike_readout_accumulator.sv
// spike_readout_accumulator: windowed per-neuron saturating spike counts, drained one neuron per valid/ready beat
module spike_readout_accumulator #(
    parameter int Spike_neurons = 15,
    parameter int WINDOW = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [0:Spike_neurons] spike_record,
    input  logic                   spike_valid,
    output logic [COUNT_WIDTH-1:0] count_data,
    output logic [3:0]             count_idx,
    output logic                   count_valid,
    input  logic                   count_ready,
    output logic                   count_last,
    output logic                   busy,
    output logic                   overrun
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    localparam logic [15:0] WIN = 16'(WINDOW);
    localparam logic [3:0] LAST = 4'(Spike_neurons);
    state_t state, state_n;
    logic [COUNT_WIDTH-1:0] cnt [0:Spike_neurons];
    logic [COUNT_WIDTH-1:0] cnt_n [0:Spike_neurons];
    logic [15:0] step_cnt, step_n;
    logic [3:0] idx_n;
    logic ovr_n, hs;
    // IDLE holds all-zero counters, so the first strobe of a window takes the same accumulate path as ACCUM
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        step_n = step_cnt;
        idx_n = count_idx;
        ovr_n = overrun;
        hs = count_valid && count_ready;
        if (state != DRAIN && spike_valid) begin
            for (int i = 0; i <= Spike_neurons; i++)
                cnt_n[i] = (spike_record[i] && cnt[i] != '1) ? cnt[i] + COUNT_WIDTH'(1) : cnt[i];
            step_n = step_cnt + 16'd1;
            state_n = (step_n == WIN) ? DRAIN : ACCUM;
        end
        if (state == DRAIN) begin
            ovr_n = overrun | spike_valid;
            if (hs && count_idx == LAST) begin
                for (int i = 0; i <= Spike_neurons; i++)
                    cnt_n[i] = '0;
                step_n = '0;
                idx_n = '0;
                state_n = IDLE;
            end else if (hs) begin
                idx_n = count_idx + 4'd1;
            end
        end
    end
    // Outputs are registered from next-state values, so count_ready never reaches count_valid combinationally
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '{default: '0};
            step_cnt <= '0;
            count_idx <= '0;
            count_valid <= 1'b0;
            count_last <= 1'b0;
            count_data <= '0;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            step_cnt <= step_n;
            count_idx <= idx_n;
            overrun <= ovr_n;
            count_valid <= state_n == DRAIN;
            count_last <= state_n == DRAIN && idx_n == LAST;
            busy <= state_n != IDLE;
            count_data <= (state_n == DRAIN) ? cnt_n[idx_n] : '0;
        end
    end
endmodule

// File: tb/tb_spike_readout_accumulator.sv
// tb_spike_readout_accumulator: table vectors, hand corner sequences and randomized windows vs a count model
module tb_spike_readout_accumulator;
    logic clock = 0, reset = 0;
    logic [0:15] rec = '0, s_rec = '0, w_rec = '0;
    logic sv = 0, rdy = 0, s_sv = 0, s_rdy = 0, w_sv = 0, w_rdy = 0;
    logic [7:0] data, w_data;
    logic [3:0] s_data, idx, s_idx, w_idx;
    logic cv, last, busy, ovr, s_cv, s_last, s_busy, s_ovr, w_cv, w_last, w_busy, w_ovr;
    int pass_n = 0, tot_n = 0;
    int ev[16];
    int m[16];
    bit ovr_exp = 0;

    always #5 clock = ~clock;

    spike_readout_accumulator dut (
        .clock(clock), .reset(reset), .spike_record(rec), .spike_valid(sv),
        .count_data(data), .count_idx(idx), .count_valid(cv), .count_ready(rdy),
        .count_last(last), .busy(busy), .overrun(ovr));
    spike_readout_accumulator #(.WINDOW(20), .COUNT_WIDTH(4)) dut_s (
        .clock(clock), .reset(reset), .spike_record(s_rec), .spike_valid(s_sv),
        .count_data(s_data), .count_idx(s_idx), .count_valid(s_cv), .count_ready(s_rdy),
        .count_last(s_last), .busy(s_busy), .overrun(s_ovr));
    spike_readout_accumulator #(.WINDOW(1)) dut_w (
        .clock(clock), .reset(reset), .spike_record(w_rec), .spike_valid(w_sv),
        .count_data(w_data), .count_idx(w_idx), .count_valid(w_cv), .count_ready(w_rdy),
        .count_last(w_last), .busy(w_busy), .overrun(w_ovr));

    typedef struct {
        logic [0:15] rec;
        int gap;
        logic [0:15] hit;
        int val;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input int act, input int expv);
        tot_n++;
        if (act == expv) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic [0:15] r, input int gap);
        rec = r;
        sv = 1;
        tick();
        sv = 0;
        repeat (gap) tick();
    endtask

    task automatic window16(input logic [0:15] r, input int gap);
        for (int j = 0; j < 16; j++) begin
            if (j == 15) chk("early_valid", cv, 0);
            strobe(r, j == 15 ? 0 : gap);
            if (j == 0) chk("accum_busy", busy, 1);
        end
        chk("latency_valid", cv, 1);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int e[16], input int mode, input bit inj);
        int k = 0;
        int cyc = 0;
        while (k < 16 && cyc < 400) begin
            rdy = (mode == 0) || (mode == 1 && (cyc % 4 == 0 || cyc % 4 == 3)) ||
                  (mode == 2 && $urandom_range(0, 1) == 1);
            sv = inj && cv && $urandom_range(0, 7) == 0;
            rec = 16'($urandom);
            if (sv) ovr_exp = 1;
            if (cv) begin
                chk("drain_idx", int'(idx), k);
                chk("drain_data", int'(data), e[k]);
                if (rdy) begin
                    chk("drain_last", last, k == 15);
                    k++;
                end
            end
            tick();
            cyc++;
        end
        sv = 0;
        rdy = 0;
        if (k < 16) chk("drain_timeout", k, 16);
        chk("post_valid", cv, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        tbl[0] = '{16'b1011110111110110, 0, 16'b1011110111110110, 16};
        tbl[1] = '{16'hFFFF, 1, 16'hFFFF, 16};
        tbl[2] = '{16'h0000, 0, 16'h0000, 0};
        tbl[3] = '{16'h8001, 2, 16'h8001, 16};

        tick();
        tick();
        chk("rst_valid", cv, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_data", int'(data), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_last", last, 0);
        reset = 1;
        tick();

        for (int t = 0; t < 4; t++) begin
            window16(tbl[t].rec, tbl[t].gap);
            for (int i = 0; i < 16; i++) ev[i] = tbl[t].hit[i] ? tbl[t].val : 0;
            drain(ev, 0, 0);
            chk("table_ovr", ovr, 0);
        end

        for (int j = 0; j < 16; j++) strobe(j % 2 == 0 ? 16'hFFFF : 16'h0000, j == 15 ? 0 : 3);
        chk("gap_latency", cv, 1);
        for (int i = 0; i < 16; i++) ev[i] = 8;
        drain(ev, 1, 0);

        window16(16'hFFFF, 0);
        rec = 16'hFFFF;
        sv = 1;
        tick();
        sv = 0;
        tick();
        sv = 1;
        tick();
        sv = 0;
        chk("ovr_set", ovr, 1);
        chk("ovr_idx_hold", int'(idx), 0);
        chk("ovr_data_hold", int'(data), 16);
        ovr_exp = 1;
        for (int i = 0; i < 16; i++) ev[i] = 16;
        drain(ev, 0, 0);
        window16(16'h0001, 0);
        for (int i = 0; i < 16; i++) ev[i] = (i == 15) ? 16 : 0;
        drain(ev, 0, 0);
        chk("ovr_sticky", ovr, 1);

        for (int w = 0; w < 4; w++) begin
            logic [0:15] r;
            for (int i = 0; i < 16; i++) m[i] = 0;
            for (int j = 0; j < 16; j++) begin
                r = 16'($urandom);
                for (int i = 0; i < 16; i++) m[i] += r[i] ? 1 : 0;
                strobe(r, j == 15 ? 0 : $urandom_range(0, 2));
            end
            for (int i = 0; i < 16; i++) ev[i] = m[i] > 255 ? 255 : m[i];
            drain(ev, 2, 1);
            chk("rand_ovr", ovr, int'(ovr_exp));
        end

        for (int j = 0; j < 5; j++) strobe(16'hFFFF, 0);
        reset = 0;
        tick();
        chk("rst_accum_valid", cv, 0);
        chk("rst_accum_busy", busy, 0);
        chk("rst_accum_ovr", ovr, 0);
        reset = 1;
        ovr_exp = 0;
        window16(16'hFFFF, 0);
        for (int i = 0; i < 16; i++) ev[i] = 16;
        drain(ev, 0, 0);
        window16(16'hFFFF, 0);
        rdy = 1;
        repeat (3) tick();
        rdy = 0;
        chk("part_idx", int'(idx), 3);
        reset = 0;
        tick();
        chk("rst_drain_valid", cv, 0);
        chk("rst_drain_busy", busy, 0);
        chk("rst_drain_idx", int'(idx), 0);
        reset = 1;
        window16(16'h00FF, 0);
        for (int i = 0; i < 16; i++) ev[i] = (i >= 8) ? 16 : 0;
        drain(ev, 0, 0);

        s_rec = 16'hFFFF;
        for (int j = 0; j < 20; j++) begin
            s_sv = 1;
            tick();
            s_sv = 0;
        end
        chk("sat_valid", s_cv, 1);
        s_rdy = 1;
        begin
            int k = 0;
            int cyc = 0;
            while (k < 16 && cyc < 100) begin
                if (s_cv) begin
                    chk("sat_idx", int'(s_idx), k);
                    chk("sat_data", int'(s_data), 15);
                    k++;
                end
                tick();
                cyc++;
            end
            if (k < 16) chk("sat_timeout", k, 16);
        end
        s_rdy = 0;
        chk("sat_post_valid", s_cv, 0);

        w_rec = 16'h8001;
        w_sv = 1;
        tick();
        w_sv = 0;
        chk("w1_valid", w_cv, 1);
        chk("w1_busy", w_busy, 1);
        w_rdy = 1;
        begin
            int k = 0;
            int cyc = 0;
            while (k < 16 && cyc < 100) begin
                if (w_cv) begin
                    chk("w1_idx", int'(w_idx), k);
                    chk("w1_data", int'(w_data), (k == 0 || k == 15) ? 1 : 0);
                    chk("w1_last", w_last, k == 15);
                    k++;
                end
                tick();
                cyc++;
            end
            if (k < 16) chk("w1_timeout", k, 16);
        end
        w_rdy = 0;
        chk("w1_post_valid", w_cv, 0);
        chk("w1_post_busy", w_busy, 0);

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/spike_readout_accumulator.md
Name: spike_readout_accumulator

Overview:
Receive-side readout for the reservoir crossbar. Samples the per-timestep spike_record vector on each spike_valid strobe, normally driven by the crossbar's flush_weight. Accumulates a saturating spike count per neuron over a fixed window of timesteps. Then drains the counts one neuron at a time over a valid/ready stream to the classifier/host side.

Parameters:
Spike_neurons, 15, index of the last neuron; the vector is [0:Spike_neurons], so there are 16 neurons.
WINDOW, 16, timesteps per accumulation window; legal range 1..2^16-1.
COUNT_WIDTH, 8, width of each per-neuron counter and of count_data.

Ports:
clock  input  1  single rising-edge clock.
reset  input  1  synchronous reset, active-low (0 = reset).
spike_record  input  [0:Spike_neurons]  spike vector from the crossbar; bit i = neuron i.
spike_valid  input  1  one-cycle strobe; spike_record is valid this cycle.
count_data  output  [COUNT_WIDTH-1:0]  spike count of neuron count_idx.
count_idx  output  [3:0]  neuron index of the current count word.
count_valid  output  1  count_data and count_idx are valid.
count_ready  input  1  consumer accepts the word when count_valid && count_ready.
count_last  output  1  high with the word for neuron Spike_neurons.
busy  output  1  high in ACCUM or DRAIN.
overrun  output  1  sticky flag: a spike_valid was dropped during DRAIN.

Behaviour:
- Reset: applied while reset==0 at a clock edge. Effect:
  - State goes to IDLE.
  - All counters, step_cnt and count_idx = 0.
  - count_valid, count_last, busy and overrun = 0; count_data = 0.
  - Reset mid-ACCUM or mid-DRAIN aborts the window; no partial output is emitted.
- State IDLE:
  - Counters are all 0.
  - On spike_valid: add spike_record into the counters, set step_cnt = 1, go to ACCUM.
  - Special case WINDOW==1: go directly to DRAIN instead.
- State ACCUM:
  - Each spike_valid adds bit i of spike_record to counter i and increments step_cnt.
  - Cycles without spike_valid leave all state unchanged; gaps between strobes are allowed.
  - When the sampled strobe makes step_cnt == WINDOW, go to DRAIN.
  - count_valid rises the cycle after the WINDOW-th strobe is sampled (latency 1).
- Saturation: each counter saturates at 2^COUNT_WIDTH-1 and never wraps.
- State DRAIN:
  - count_valid = 1; count_idx starts at 0.
  - count_data = counter[count_idx]; count_last = (count_idx == Spike_neurons).
  - Outputs are held stable while count_ready is 0.
  - On a handshake (count_valid && count_ready), count_idx increments.
  - Handshake on the last word: clear all counters, step_cnt and count_idx; go to IDLE. count_valid is 0 on the next cycle.
  - A full drain takes at least 16 cycles (back-to-back ready).
- spike_valid during DRAIN: the strobe is ignored (no count change) and overrun is set to 1. overrun stays 1 until reset.
- spike_valid on the same cycle as the last-word handshake: counts as dropped and sets overrun. The next window starts on the next strobe seen in IDLE.
- busy = (state != IDLE), registered.
- All outputs are registered; there is no combinational path from count_ready to count_valid.

Test Plan:
1. Nominal window. Reset low 2 cycles, then high. Send 16 back-to-back strobes with spike_record=16'b1011110111110110, count_ready=1.
   Expect 16 words, idx 0..15, with counts 16,0,16,16,16,16,0,16,16,16,16,16,0,16,16,0. count_last only on idx 15. overrun=0. Then IDLE and busy=0.
2. Gapped strobes and backpressure. Send 16 strobes separated by 3 idle cycles, alternating 16'hFFFF and 16'h0000. Toggle count_ready 1,0,0,1.
   Expect all counts = 8. Each word is held unchanged while ready=0. Exactly 16 handshakes.
3. Overrun. Complete a window; hold count_ready=0 in DRAIN and pulse spike_valid twice.
   Expect overrun=1 and counts unchanged (all values from the prior window). After drain, the next window counts from 0 and overrun stays 1.
4. Saturation. Set COUNT_WIDTH=4, WINDOW=20; send 20 strobes of 16'hFFFF.
   Expect every count = 15 (no wrap to 4).
5. Reset mid-operation. Assert reset low after 5 strobes in ACCUM, and again after 3 handshakes in DRAIN.
   Expect count_valid=0 and busy=0 the next cycle. The following full window reports fresh counts with no residue.
6. WINDOW=1. Send a single strobe of 16'h8001.
   Expect DRAIN the next cycle with idx0=1, idx15=1, all others 0.
